rr_mux4_arbiter: RTL and testbench
==================================

Name: rr_mux4_arbiter

Overview:
- Round-robin arbiter that shares one 4:1 mux datapath among four requesters.
- It generates the one-hot grant and the mux select pair (s1,s0), and registers the selected data.
- A per-grant hold limit stops any one requester from monopolising the mux.
- It sits in front of the 4:1 mux and replaces hand-driven select lines with a sequenced controller.

Parameters:
- W, 1, data width of each requester lane and of dout.
- MAX_HOLD, 4, maximum consecutive cycles one requester may hold the grant while others wait; legal range 1..15.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  reset, asynchronous, active-high; clears all state immediately.
- req  input  4  request per lane; req[k] is level-sensitive.
- din  input  4*W  lane data; lane k occupies din[k*W +: W].
- gnt  output  4  one-hot grant, registered; all-zero when idle.
- s1  output  1  select MSB = owner index bit 1, registered.
- s0  output  1  select LSB = owner index bit 0, registered.
- busy  output  1  high while any grant is active (= |gnt).
- dout  output  W  registered mux output = din lane of current owner, one cycle after grant.
- dout_vld  output  1  high when dout carries data from a granted lane.

Behaviour:
- Reset values: gnt=0000, s1=0, s0=0, busy=0, dout=0, dout_vld=0.
- Reset internals: ptr (last owner) = 2'b11, so lane 0 has first priority; hold_cnt=0; state=IDLE.
- States: IDLE, GRANT.
- Round-robin search order: ptr+1, ptr+2, ptr+3, ptr, all modulo 4 (2-bit wrap, 3 -> 0).
- IDLE:
  - If req != 0, the winner is found by the search order.
  - Next edge: gnt=onehot(winner), {s1,s0}=winner, ptr=winner, hold_cnt=0, state -> GRANT.
  - If req == 0, stay in IDLE with outputs unchanged at zero.
- GRANT, each edge, with owner = ptr:
  - Keep: req[owner]=1 and (hold_cnt < MAX_HOLD-1 or no other req bit set). Keep the grant; hold_cnt increments, saturating at MAX_HOLD-1.
  - Rotate: req[owner]=0, or hold_cnt == MAX_HOLD-1 with another lane requesting. Re-arbitrate in the same cycle from ptr+1; the new winner is granted at this edge with no idle bubble, ptr=winner, hold_cnt=0.
  - Release: no req bit set. gnt=0000, state -> IDLE; {s1,s0} hold their last value; ptr is kept.
- Expiry with no contender: if hold_cnt reaches MAX_HOLD-1 and only the owner requests, the owner keeps the grant and hold_cnt stays saturated.
- Datapath:
  - Every edge: dout <= din[owner lane] if gnt != 0, else 0.
  - dout_vld <= |gnt, so data appears exactly 1 cycle after the corresponding grant.
- Simultaneous events:
  - A request rising on the same edge the owner drops is eligible in that arbitration.
  - Multiple simultaneous new requests are resolved purely by the search order.
- req is sampled only at clk edges; glitches between edges are ignored.
- Reset asserted mid-grant:
  - All outputs go to reset values without waiting for clk.
  - After release, the first arbitration again favours lane 0.
- gnt is never multi-hot. {s1,s0} always encodes the set bit while gnt != 0.

Test Plan:
- Reset, then req=0000 for 5 cycles -> gnt=0000, busy=0, dout_vld=0 throughout. Then assert rst mid-cycle -> outputs are zero before the next clk edge.
- req=0001, din lane0=1, others 0, W=1 -> gnt=0001 and s1s0=00 one edge after the request; dout=1 with dout_vld=1 one edge later. Drop req -> gnt=0000 next edge, dout_vld=0 the edge after.
- req=1111 held, MAX_HOLD=4 -> grant sequence 0001,0010,0100,1000,0001, each held exactly 4 cycles. s1s0 follows 00,01,10,11,00.
- req=0100 only, held 10 cycles -> gnt=0100 for all 10 cycles, no rotation, no bubble.
- Owner lane 1 drops req on the same edge lane 3 rises, with lane 0 also requesting -> next grant is lane 3 (search from 2), with no idle cycle between grants.
- Assert rst while gnt=1000 -> gnt=0000 immediately. Release rst with req=1001 -> first grant is lane 0 (0001).

Source files
------------

// File: rtl/rr_mux4_arbiter_if.sv
// Bundle of requester-side and mux-side signals for the 4-lane round-robin arbiter.
// The master side owns the requests and lane data; the slave side (the arbiter)
// returns the grant, mux select and registered data.
interface rr_mux4_arbiter_if #(
    parameter int unsigned W = 1
);
    logic [3:0]     req;
    logic [4*W-1:0] din;
    logic [3:0]     gnt;
    logic           s1;
    logic           s0;
    logic           busy;
    logic [W-1:0]   dout;
    logic           dout_vld;

    modport master (
        output req,
        output din,
        input  gnt,
        input  s1,
        input  s0,
        input  busy,
        input  dout,
        input  dout_vld
    );

    modport slave (
        input  req,
        input  din,
        output gnt,
        output s1,
        output s0,
        output busy,
        output dout,
        output dout_vld
    );
endinterface

// File: rtl/rr_mux4_arbiter.sv
// Round-robin arbiter driving a shared 4:1 mux.
// Produces a registered one-hot grant, the matching select pair {s1,s0}, and a
// registered copy of the owner's lane data one cycle after the grant. A hold
// limit forces rotation when the owner has held the mux for MAX_HOLD cycles
// while another lane is waiting. MAX_HOLD must lie in 1..15.
module rr_mux4_arbiter #(
    parameter int unsigned W        = 1,
    parameter int unsigned MAX_HOLD = 4
) (
    input logic                 clk,
    input logic                 rst,
    rr_mux4_arbiter_if.slave    bus
);

    typedef enum logic [0:0] {
        StIdle,
        StGrant
    } state_e;

    // Last hold count value before the owner must yield to a contender.
    localparam logic [3:0] HoldLast = 4'(MAX_HOLD - 1);

    state_e         state_q, state_d;
    logic [1:0]     ptr_q, ptr_d;     // last (or current) owner
    logic [3:0]     hold_q, hold_d;
    logic [3:0]     gnt_q, gnt_d;
    logic [1:0]     sel_q, sel_d;
    logic [W-1:0]   dout_q, dout_d;
    logic           vld_q, vld_d;

    logic           found;
    logic [1:0]     winner;
    logic           owner_req;
    logic           others_req;

    // Round-robin search: ptr+1, ptr+2, ptr+3, then ptr itself (2-bit wrap).
    always_comb begin
        found  = 1'b0;
        winner = ptr_q;
        for (int i = 1; i <= 4; i++) begin
            if (!found && bus.req[ptr_q + 2'(i)]) begin
                found  = 1'b1;
                winner = ptr_q + 2'(i);
            end
        end
    end

    // Owner's own request and whether any other lane is contending.
    always_comb begin
        owner_req  = bus.req[ptr_q];
        others_req = |(bus.req & ~(4'b0001 << ptr_q));
    end

    // Next-state logic: grant, keep, rotate or release.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        hold_d  = hold_q;
        gnt_d   = gnt_q;
        sel_d   = sel_q;

        unique case (state_q)
            StIdle: begin
                if (found) begin
                    gnt_d   = 4'b0001 << winner;
                    sel_d   = winner;
                    ptr_d   = winner;
                    hold_d  = 4'd0;
                    state_d = StGrant;
                end
            end
            StGrant: begin
                if (bus.req == 4'b0000) begin
                    // Release: select lines and ptr keep their last value.
                    gnt_d   = 4'b0000;
                    state_d = StIdle;
                end else if (owner_req && ((hold_q < HoldLast) || !others_req)) begin
                    // Keep; the count saturates so a lone owner holds indefinitely.
                    if (hold_q < HoldLast) begin
                        hold_d = hold_q + 4'd1;
                    end
                end else begin
                    // Rotate without an idle bubble; req != 0 guarantees a winner.
                    gnt_d  = 4'b0001 << winner;
                    sel_d  = winner;
                    ptr_d  = winner;
                    hold_d = 4'd0;
                end
            end
            default: begin
                gnt_d   = 4'b0000;
                state_d = StIdle;
            end
        endcase
    end

    // Datapath: capture the current owner's lane while a grant is active.
    always_comb begin
        dout_d = '0;
        vld_d  = |gnt_q;
        if (|gnt_q) begin
            dout_d = bus.din[32'(ptr_q) * W +: W];
        end
    end

    // State and output registers; reset favours lane 0 on the first arbitration.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            ptr_q   <= 2'b11;
            hold_q  <= 4'd0;
            gnt_q   <= 4'b0000;
            sel_q   <= 2'b00;
            dout_q  <= '0;
            vld_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            hold_q  <= hold_d;
            gnt_q   <= gnt_d;
            sel_q   <= sel_d;
            dout_q  <= dout_d;
            vld_q   <= vld_d;
        end
    end

    assign bus.gnt      = gnt_q;
    assign bus.s1       = sel_q[1];
    assign bus.s0       = sel_q[0];
    assign bus.busy     = |gnt_q;
    assign bus.dout     = dout_q;
    assign bus.dout_vld = vld_q;

endmodule

// File: tb/tb_rr_mux4_arbiter.sv
// Scoreboard bench for rr_mux4_arbiter (W=1, MAX_HOLD=4): the driver pushes the
// hand-computed post-edge outputs for each applied vector, the monitor pops and
// compares just after every rising edge.
module tb_rr_mux4_arbiter;

    typedef struct packed {
        logic [3:0]  gnt;
        logic [1:0]  sel;
        logic        dout;
        logic        vld;
        int unsigned id;
    } exp_t;

    logic clk;
    logic rst;
    int   n_chk;
    int   n_err;
    int   step_id;
    exp_t exp_q[$];

    rr_mux4_arbiter_if #(.W(1)) bus ();

    rr_mux4_arbiter #(
        .W        (1),
        .MAX_HOLD (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Apply one vector at a negedge, queue the outputs expected after the next
    // rising edge, then return at the following negedge.
    task automatic step(input logic [3:0] r, input logic [3:0] d, input logic [3:0] eg,
                        input logic [1:0] es, input logic ed, input logic ev);
        exp_t e;
        bus.req = r;
        bus.din = d;
        e.gnt = eg;
        e.sel = es;
        e.dout = ed;
        e.vld = ev;
        e.id = step_id;
        exp_q.push_back(e);
        step_id++;
        @(negedge clk);
    endtask

    // Asynchronous reset mid-cycle; outputs must clear before any clock edge.
    task automatic do_reset(input logic [3:0] r_after);
        #2 rst = 1'b1;
        #1;
        chk("async rst gnt", 8'(bus.gnt), 8'h0);
        chk("async rst sel", 8'({bus.s1, bus.s0}), 8'h0);
        chk("async rst busy", 8'(bus.busy), 8'h0);
        chk("async rst dout", 8'(bus.dout), 8'h0);
        chk("async rst vld", 8'(bus.dout_vld), 8'h0);
        bus.req = r_after;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Monitor: compare queued expectations and structural invariants each edge.
    initial begin
        exp_t e;
        logic [1:0] enc;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                n_chk++;
                if (bus.gnt !== e.gnt || {bus.s1, bus.s0} !== e.sel || bus.dout !== e.dout ||
                    bus.dout_vld !== e.vld || bus.busy !== (|e.gnt)) begin
                    n_err++;
                    $display("FAIL step %0d: got gnt=%b sel=%b dout=%b vld=%b busy=%b want gnt=%b sel=%b dout=%b vld=%b busy=%b",
                             e.id, bus.gnt, {bus.s1, bus.s0}, bus.dout, bus.dout_vld, bus.busy,
                             e.gnt, e.sel, e.dout, e.vld, |e.gnt);
                end
                if (bus.gnt != 4'b0000) begin
                    enc = 2'b00;
                    for (int k = 0; k < 4; k++) begin
                        if (bus.gnt[k]) enc = 2'(k);
                    end
                    n_chk++;
                    if ($countones(bus.gnt) != 1 || {bus.s1, bus.s0} !== enc) begin
                        n_err++;
                        $display("FAIL onehot/sel step %0d: got gnt=%b sel=%b", e.id, bus.gnt,
                                 {bus.s1, bus.s0});
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [3:0] d;
        int lane;
        int prev;
        n_chk = 0;
        n_err = 0;
        step_id = 0;
        rst = 1'b1;
        bus.req = 4'b0000;
        bus.din = 4'b0000;
        #3;
        chk("reset gnt", 8'(bus.gnt), 8'h0);
        chk("reset sel", 8'({bus.s1, bus.s0}), 8'h0);
        chk("reset busy", 8'(bus.busy), 8'h0);
        chk("reset dout", 8'(bus.dout), 8'h0);
        chk("reset vld", 8'(bus.dout_vld), 8'h0);
        @(negedge clk);
        rst = 1'b0;

        // Idle with no requests.
        for (int i = 0; i < 5; i++) step(4'b0000, 4'b1111, 4'b0000, 2'b00, 1'b0, 1'b0);
        do_reset(4'b0000);

        // Single request on lane 0, then drop.
        step(4'b0001, 4'b0001, 4'b0001, 2'b00, 1'b0, 1'b0);
        step(4'b0001, 4'b0001, 4'b0001, 2'b00, 1'b1, 1'b1);
        step(4'b0000, 4'b0001, 4'b0000, 2'b00, 1'b1, 1'b1);
        step(4'b0000, 4'b0001, 4'b0000, 2'b00, 1'b0, 1'b0);
        do_reset(4'b0000);

        // All lanes requesting: each holds exactly 4 cycles, order 0,1,2,3,0.
        d = 4'b1010;
        for (int k = 0; k < 20; k++) begin
            lane = (k / 4) % 4;
            prev = ((k - 1) / 4) % 4;
            if (k == 0) step(4'b1111, d, 4'b0001, 2'b00, 1'b0, 1'b0);
            else step(4'b1111, d, 4'(1 << lane), 2'(lane), d[prev], 1'b1);
        end

        // Lane 2 alone for 10 cycles: immediate takeover, hold saturates, no rotation.
        step(4'b0100, 4'b0100, 4'b0100, 2'b10, 1'b0, 1'b1);
        for (int i = 0; i < 9; i++) step(4'b0100, 4'b0100, 4'b0100, 2'b10, 1'b1, 1'b1);

        // Owner 1 drops as lane 3 rises with lane 0 waiting: search from 2 picks 3.
        step(4'b0010, 4'b1010, 4'b0010, 2'b01, 1'b0, 1'b1);
        step(4'b0011, 4'b1010, 4'b0010, 2'b01, 1'b1, 1'b1);
        step(4'b1001, 4'b1010, 4'b1000, 2'b11, 1'b1, 1'b1);
        step(4'b1001, 4'b1010, 4'b1000, 2'b11, 1'b1, 1'b1);
        step(4'b1001, 4'b1010, 4'b1000, 2'b11, 1'b1, 1'b1);

        // Reset while lane 3 owns; first grant afterwards goes to lane 0.
        do_reset(4'b1001);
        step(4'b1001, 4'b1011, 4'b0001, 2'b00, 1'b0, 1'b0);
        step(4'b1001, 4'b1011, 4'b0001, 2'b00, 1'b1, 1'b1);
        step(4'b0000, 4'b1011, 4'b0000, 2'b00, 1'b1, 1'b1);
        step(4'b0000, 4'b1011, 4'b0000, 2'b00, 1'b0, 1'b0);

        @(negedge clk);
        chk("scoreboard drained", 8'(exp_q.size()), 8'h0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
